// File: rtl/ling_arb_pkg.sv
// Shared types and helpers for the Ling-adder arbiter slice.
package ling_arb_pkg;

   localparam int LING_W = 32;

   typedef logic [LING_W-1:0] ling_word_t;

   // Round-robin successor of ptr in a ring of n entries.
   function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
      return (ptr + 1 >= n) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/ling_adder32.sv
// 32-bit sparse Ling adder: group pseudo-carries every 4 bits via a Kogge-Stone
// tree, local ripple of H inside each group, carry recovered as c = t & H.
module ling_adder32
   import ling_arb_pkg::*;
(
   input  ling_word_t i_a,
   input  ling_word_t i_b,
   output ling_word_t o_sum
);
   localparam int NG = LING_W / 4;

   ling_word_t        w_g, w_t, w_p, w_lg, w_lt, w_h, w_c;
   logic [NG-1:0]     w_gg, w_gt;
   logic [3:0][NG-1:0] w_kg, w_kt;
   logic              w_hin;

   assign w_g  = i_a & i_b;
   assign w_t  = i_a | i_b;
   assign w_p  = i_a ^ i_b;
   // Ling recurrence H_i = g_i | t_(i-1) & H_(i-1): the propagate term is shifted by one
   assign w_lg = w_g;
   assign w_lt = {w_t[LING_W-2:0], 1'b0};

   always_comb begin
      w_gg = '0;
      w_gt = '0;
      for (int j = 0; j < NG; j++) begin
         w_gg[j] = w_lg[4*j];
         w_gt[j] = w_lt[4*j];
         for (int k = 1; k < 4; k++) begin
            w_gg[j] = w_lg[4*j+k] | (w_lt[4*j+k] & w_gg[j]);
            w_gt[j] = w_lt[4*j+k] & w_gt[j];
         end
      end
   end

   always_comb begin
      w_kg    = '0;
      w_kt    = '0;
      w_kg[0] = w_gg;
      w_kt[0] = w_gt;
      for (int l = 0; l < 3; l++) begin
         for (int j = 0; j < NG; j++) begin
            if (j >= (1 << l)) begin
               w_kg[l+1][j] = w_kg[l][j] | (w_kt[l][j] & w_kg[l][j-(1<<l)]);
               w_kt[l+1][j] = w_kt[l][j] & w_kt[l][j-(1<<l)];
            end else begin
               w_kg[l+1][j] = w_kg[l][j];
               w_kt[l+1][j] = w_kt[l][j];
            end
         end
      end
   end

   always_comb begin
      w_h   = '0;
      w_hin = 1'b0;
      for (int j = 0; j < NG; j++) begin
         w_hin = (j == 0) ? 1'b0 : w_kg[3][j-1];
         for (int k = 0; k < 4; k++) begin
            w_h[4*j+k] = w_lg[4*j+k] | (w_lt[4*j+k] & w_hin);
            w_hin      = w_h[4*j+k];
         end
      end
   end

   assign w_c   = {w_t[LING_W-2:0] & w_h[LING_W-2:0], 1'b0};
   assign o_sum = w_p ^ w_c;

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin priority search starting at ptr; grant is suppressed when en is low.
module rr_arbiter #(
   parameter int N_REQ = 4,
   parameter int ID_W  = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  ptr,
   input  logic             en,
   output logic [N_REQ-1:0] gnt,
   output logic [ID_W-1:0]  win
);
   logic w_found;

   always_comb begin
      w_found = 1'b0;
      win     = '0;
      gnt     = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (!w_found && req[(int'(ptr) + k) % N_REQ]) begin
            w_found = 1'b1;
            win     = ID_W'((int'(ptr) + k) % N_REQ);
         end
      end
      if (w_found && en) gnt = N_REQ'(1) << win;
   end

endmodule

// File: rtl/ling_add_arbiter.sv
// Round-robin sharing of one 32-bit Ling adder core among N_REQ requesters.
// LING_ARB_OUT_REG_EN adds the S2 result register (latency 2); otherwise rsp_* come from S1 through the core.
module ling_add_arbiter
   import ling_arb_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int ID_W  = $clog2(N_REQ)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [N_REQ-1:0]        req_valid,
   output logic [N_REQ-1:0]        req_ready,
   input  logic [N_REQ*LING_W-1:0] req_a,
   input  logic [N_REQ*LING_W-1:0] req_b,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output ling_word_t              rsp_sum,
   output logic [ID_W-1:0]         rsp_id,
   output logic                    busy
);
   logic            r_s1_v;
   ling_word_t      r_s1_a, r_s1_b;
   logic [ID_W-1:0] r_s1_id, r_ptr;

   logic [ID_W-1:0]  w_win;
   logic [N_REQ-1:0] w_gnt;
   logic             w_s1_free, w_s1_drain, w_acc;
   ling_word_t       w_sel_a, w_sel_b, w_core_sum;

   // Grants are masked while reset is held so req_ready reads 0 asynchronously
   rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
      .req (req_valid),
      .ptr (r_ptr),
      .en  (w_s1_free & rst_n),
      .gnt (w_gnt),
      .win (w_win)
   );

   assign req_ready = w_gnt;
   assign w_acc     = |(req_valid & w_gnt);
   assign w_sel_a   = req_a[int'(w_win)*LING_W +: LING_W];
   assign w_sel_b   = req_b[int'(w_win)*LING_W +: LING_W];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr <= '0;
      end else if (w_acc) begin
         r_ptr <= ID_W'(rr_next(32'(w_win), N_REQ));
      end
   end

   // S1: issue register feeding the adder core
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_v  <= 1'b0;
         r_s1_a  <= '0;
         r_s1_b  <= '0;
         r_s1_id <= '0;
      end else if (w_acc) begin
         r_s1_v  <= 1'b1;
         r_s1_a  <= w_sel_a;
         r_s1_b  <= w_sel_b;
         r_s1_id <= w_win;
      end else if (w_s1_drain) begin
         r_s1_v  <= 1'b0;
      end
   end

   ling_adder32 u_core (
      .i_a   (r_s1_a),
      .i_b   (r_s1_b),
      .o_sum (w_core_sum)
   );

`ifdef LING_ARB_OUT_REG_EN
   logic            r_s2_v;
   ling_word_t      r_s2_sum;
   logic [ID_W-1:0] r_s2_id;
   logic            w_s2_load;

   assign w_s2_load  = r_s1_v & (~r_s2_v | rsp_ready);
   assign w_s1_drain = w_s2_load;
   assign w_s1_free  = ~r_s1_v | w_s2_load;

   // S2: result register, held under backpressure
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s2_v   <= 1'b0;
         r_s2_sum <= '0;
         r_s2_id  <= '0;
      end else if (w_s2_load) begin
         r_s2_v   <= 1'b1;
         r_s2_sum <= w_core_sum;
         r_s2_id  <= r_s1_id;
      end else if (rsp_ready) begin
         r_s2_v   <= 1'b0;
      end
   end

   assign rsp_valid = r_s2_v;
   assign rsp_sum   = r_s2_sum;
   assign rsp_id    = r_s2_id;
   assign busy      = r_s1_v | r_s2_v;
`else
   assign w_s1_drain = r_s1_v & rsp_ready;
   assign w_s1_free  = ~r_s1_v | rsp_ready;
   assign rsp_valid  = r_s1_v;
   assign rsp_sum    = w_core_sum;
   assign rsp_id     = r_s1_id;
   assign busy       = r_s1_v;
`endif

endmodule

// File: tb/tb_ling_add_arbiter.sv
// Bench for ling_add_arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_ling_add_arbiter;
   import ling_arb_pkg::*;

   localparam int N   = 4;
   localparam int IDW = 2;
`ifdef LING_ARB_OUT_REG_EN
   localparam int CAP = 2;
   localparam int DLY = 1;
`else
   localparam int CAP = 1;
   localparam int DLY = 0;
`endif

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic [N-1:0]        req_valid;
   logic [N-1:0]        req_ready;
   logic [N*LING_W-1:0] req_a, req_b;
   logic                rsp_valid;
   logic                rsp_ready;
   ling_word_t          rsp_sum;
   logic [IDW-1:0]      rsp_id;
   logic                busy;

   always #5 clk = ~clk;

   ling_add_arbiter #(.N_REQ(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_sum   (rsp_sum),
      .rsp_id    (rsp_id),
      .busy      (busy)
   );

   typedef struct {
      logic [31:0] sum;
      int          id;
      int          acc;
   } txn_t;

   txn_t        q[$];
   int          m_ptr, edge_cnt, n_cmp, n_err;
   logic        pend[N];
   logic [31:0] opa[N], opb[N];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic load(input int i, input logic [31:0] a, input logic [31:0] b);
      if (!pend[i]) begin
         pend[i] = 1'b1;
         opa[i]  = a;
         opb[i]  = b;
      end
   endtask

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         req_valid[i]            = pend[i];
         req_a[i*LING_W +: LING_W] = opa[i];
         req_b[i*LING_W +: LING_W] = opb[i];
      end
   endtask

   function automatic int exp_win();
      for (int k = 0; k < N; k++)
         if (pend[(m_ptr + k) % N]) return (m_ptr + k) % N;
      return -1;
   endfunction

   // One clock: check outputs against the model, then advance the model on the edge
   task automatic cycle();
      int           w;
      logic         free, vis;
      logic [N-1:0] er;
      txn_t         t;
      drive();
      #1;
      w    = exp_win();
      free = (q.size() < CAP) || rsp_ready;
      er   = '0;
      if (w >= 0 && free) er[w] = 1'b1;
      vis  = (q.size() > 0) && (edge_cnt >= q[0].acc + DLY);
      chk("req_ready", 32'(req_ready), 32'(er));
      chk("rsp_valid", 32'(rsp_valid), 32'(vis));
      if (vis) begin
         chk("rsp_sum", rsp_sum, q[0].sum);
         chk("rsp_id", 32'(rsp_id), 32'(q[0].id));
      end
      chk("busy", 32'(busy), 32'(q.size() != 0));
      @(posedge clk);
      edge_cnt++;
      if (vis && rsp_ready) void'(q.pop_front());
      if (w >= 0 && free) begin
         t.sum = opa[w] + opb[w];
         t.id  = w;
         t.acc = edge_cnt;
         q.push_back(t);
         pend[w] = 1'b0;
         m_ptr   = (w + 1) % N;
      end
      @(negedge clk);
   endtask

   initial begin
      n_cmp = 0; n_err = 0; m_ptr = 0; edge_cnt = 0;
      rsp_ready = 1'b1;
      for (int i = 0; i < N; i++) begin
         pend[i] = 1'b0; opa[i] = '0; opb[i] = '0;
      end
      // Reset state, with a request already raised
      load(1, 32'h1111_1111, 32'h2222_2222);
      drive();
      @(negedge clk);
      #1;
      chk("rst_req_ready", 32'(req_ready), 32'h0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst_rsp_sum", rsp_sum, 32'h0);
      chk("rst_rsp_id", 32'(rsp_id), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      pend[1] = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      // Single request from requester 2 on an idle arbiter
      load(2, 32'h0000_0005, 32'h0000_0003);
      repeat (4) cycle();

      // All requesters continuously valid: rotating grants at full rate
      for (int n = 0; n < 12; n++) begin
         for (int i = 0; i < N; i++) load(i, $urandom, $urandom);
         cycle();
      end
      for (int i = 0; i < N; i++) pend[i] = 1'b0;
      repeat (3) cycle();

      // Backpressure: three requests while the consumer stalls, then release
      rsp_ready = 1'b0;
      load(0, 32'hFFFF_FFFF, 32'h0000_0001);
      load(1, 32'h8000_0000, 32'h8000_0000);
      load(3, 32'h1234_5678, 32'h0FED_CBA9);
      repeat (5) cycle();
      rsp_ready = 1'b1;
      repeat (5) cycle();

      // Reset with the pipeline full
      rsp_ready = 1'b0;
      for (int i = 0; i < N; i++) load(i, $urandom, $urandom);
      repeat (3) cycle();
      rst_n = 1'b0;
      #1;
      chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("mid_rst_busy", 32'(busy), 32'h0);
      chk("mid_rst_req_ready", 32'(req_ready), 32'h0);
      chk("mid_rst_rsp_sum", rsp_sum, 32'h0);
      q.delete();
      m_ptr = 0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      rsp_ready = 1'b1;
      for (int i = 0; i < N; i++) load(i, $urandom, $urandom);
      repeat (6) cycle();

      // Random traffic, including carry-chain corner operands
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(1, 0) == 1) begin
               case ($urandom_range(3, 0))
                  0:       load(i, 32'hFFFF_FFFF, $urandom_range(1, 0));
                  1:       load(i, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
                  default: load(i, $urandom, $urandom);
               endcase
            end
         end
         rsp_ready = ($urandom_range(3, 0) != 0);
         cycle();
      end
      rsp_ready = 1'b1;
      for (int n = 0; n < 8; n++) cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
